// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Arbitrates the icache and dcache request ports onto a single memory bus.
//   The grant is combinational, so mem_req_* follows the winning request in
//   the same cycle. A 16-entry owner table, indexed by the tag that memory
//   accepts, sends each data return back to the requester that issued the
//   load.
//
//   Command encoding: 0 = BUS_NONE, 1 = BUS_LOAD, 2 = BUS_STORE.
//
//   Configuration macro:
//     MEM_ARB_RR_EN  defined   -> round-robin conflict resolution
//                                 (uses a one-bit pointer)
//                    undefined -> fixed dcache priority, no pointer state
//
//   Ports:
//     clk, rst            clock; synchronous active-high reset
//     ic_req_cmd/addr     icache request (BUS_NONE / BUS_LOAD)
//     dc_req_cmd/addr/data dcache request (BUS_NONE / BUS_LOAD / BUS_STORE)
//     mem_resp_code       tag memory accepted this cycle; 0 = rejected
//     mem_resp_data/tag   data return; tag 0 = no return
//     mem_req_cmd/addr/data granted request presented to memory
//     ic_hold, dc_hold    requester lost arbitration this cycle
//     ic/dc_resp_code     mem_resp_code copy for the granted requester, else 0
//     ic/dc_resp_tag      routed return tag for the owning requester, else 0
//     resp_data           mem_resp_data passed through
//     outstanding_cnt     number of valid owner-table entries
module mem_bus_arbiter #(
  parameter int unsigned SYS_XLEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          ic_req_cmd,
  input  logic [SYS_XLEN-1:0] ic_req_addr,
  input  logic [1:0]          dc_req_cmd,
  input  logic [SYS_XLEN-1:0] dc_req_addr,
  input  logic [63:0]         dc_req_data,
  input  logic [3:0]          mem_resp_code,
  input  logic [63:0]         mem_resp_data,
  input  logic [3:0]          mem_resp_tag,
  output logic [1:0]          mem_req_cmd,
  output logic [SYS_XLEN-1:0] mem_req_addr,
  output logic [63:0]         mem_req_data,
  output logic                ic_hold,
  output logic                dc_hold,
  output logic [3:0]          ic_resp_code,
  output logic [3:0]          dc_resp_code,
  output logic [3:0]          ic_resp_tag,
  output logic [3:0]          dc_resp_tag,
  output logic [63:0]         resp_data,
  output logic [4:0]          outstanding_cnt
);

  localparam logic [1:0] BUS_NONE = 2'd0;
  localparam logic [1:0] BUS_LOAD = 2'd1;

  // Owner bit: 1 = dcache, 0 = icache.
  logic [15:0] valid_q, valid_d;
  logic [15:0] owner_q, owner_d;
  logic [4:0]  cnt_q, cnt_d;

  logic ic_req, dc_req, conflict, dc_first;
  logic grant_ic, grant_dc;
  logic [1:0] gnt_cmd;
  logic alloc, retire, alloc_inc;

`ifdef MEM_ARB_RR_EN
  // 0 = dcache wins the next conflict, 1 = icache wins it.
  logic rr_ptr_q, rr_ptr_d;

  always_comb begin
    dc_first = ~rr_ptr_q;
    rr_ptr_d = rr_ptr_q;
    // The conflict winner always matches the pointer, so toggling hands the
    // next conflict to the loser.
    if (conflict) begin
      rr_ptr_d = ~rr_ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`else
  always_comb begin
    dc_first = 1'b1;
  end
`endif

  // Grant selection.
  always_comb begin
    ic_req   = (ic_req_cmd != BUS_NONE);
    dc_req   = (dc_req_cmd != BUS_NONE);
    conflict = ic_req & dc_req;
    grant_dc = dc_req & (~ic_req | dc_first);
    grant_ic = ic_req & ~grant_dc;
    gnt_cmd  = BUS_NONE;
    if (grant_dc) begin
      gnt_cmd = dc_req_cmd;
    end else if (grant_ic) begin
      gnt_cmd = ic_req_cmd;
    end
  end

  // Owner-table and counter next state.
  always_comb begin
    valid_d = valid_q;
    owner_d = owner_q;
    retire  = (mem_resp_tag != 4'd0) && valid_q[mem_resp_tag];
    alloc   = (gnt_cmd == BUS_LOAD) && (mem_resp_code != 4'd0);
    // A retire of the same tag frees the slot this cycle, so the allocate
    // counts. An allocate onto a still-valid entry only replaces the owner.
    alloc_inc = alloc && (!valid_q[mem_resp_code] ||
                          (retire && (mem_resp_tag == mem_resp_code)));
    if (retire) begin
      valid_d[mem_resp_tag] = 1'b0;
    end
    // Applied after the retire so a same-tag allocate wins.
    if (alloc) begin
      valid_d[mem_resp_code] = 1'b1;
      owner_d[mem_resp_code] = grant_dc;
    end
    cnt_d = cnt_q + {4'd0, alloc_inc} - {4'd0, retire};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs; all forced to zero while rst is high.
  always_comb begin
    mem_req_cmd     = BUS_NONE;
    mem_req_addr    = '0;
    mem_req_data    = '0;
    ic_hold         = 1'b0;
    dc_hold         = 1'b0;
    ic_resp_code    = '0;
    dc_resp_code    = '0;
    ic_resp_tag     = '0;
    dc_resp_tag     = '0;
    resp_data       = '0;
    outstanding_cnt = '0;
    if (!rst) begin
      mem_req_cmd = gnt_cmd;
      if (grant_dc) begin
        mem_req_addr = dc_req_addr;
        mem_req_data = dc_req_data;
        dc_resp_code = mem_resp_code;
      end else if (grant_ic) begin
        mem_req_addr = ic_req_addr;
        ic_resp_code = mem_resp_code;
      end
      ic_hold = ic_req & ~grant_ic;
      dc_hold = dc_req & ~grant_dc;
      if (retire) begin
        if (owner_q[mem_resp_tag]) begin
          dc_resp_tag = mem_resp_tag;
        end else begin
          ic_resp_tag = mem_resp_tag;
        end
      end
      resp_data       = mem_resp_data;
      outstanding_cnt = cnt_q;
    end
  end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have clk input 1: clock.
REQ-002 SHALL have rst input 1: reset, synchronous, active-high.
REQ-003 SHALL have ic_req_cmd input 2: icache command (BUS_NONE/BUS_LOAD).
REQ-004 SHALL have ic_req_addr input SYS_XLEN: icache line address.
REQ-005 SHALL have dc_req_cmd input 2: dcache command (BUS_NONE/BUS_LOAD/BUS_STORE).
REQ-006 SHALL have dc_req_addr input SYS_XLEN and dc_req_data input 64: dcache address and store data.
REQ-007 SHALL have mem_resp_code input 4: tag accepted this cycle; 0 means rejected.
REQ-008 SHALL have mem_resp_data input 64 and mem_resp_tag input 4: data return; tag 0 means none.
REQ-009 SHALL have mem_req_cmd output 2, mem_req_addr output SYS_XLEN and mem_req_data output 64: granted request to memory.
REQ-010 SHALL have ic_hold output 1 and dc_hold output 1: requester lost arbitration this cycle.
REQ-011 SHALL have ic_resp_code output 4 and dc_resp_code output 4: per-requester copy of mem_resp_code; 0 when not granted.
REQ-012 SHALL have ic_resp_tag output 4, dc_resp_tag output 4 and resp_data output 64: routed data return.
REQ-013 SHALL have outstanding_cnt output 5: live tags in owner table.

Function
REQ-014 SHALL be a combinational grant: mem_req_* driven in the same cycle as the winning request; zero latency.
REQ-015 SHALL grant dc when only dc requests, ic when only ic requests, and drive BUS_NONE with zero address and data when neither requests.
REQ-016 SHALL, on conflict with MEM_ARB_RR_EN undefined, grant dc (fixed priority).
REQ-017 SHALL assert ic_hold/dc_hold only for a requester with cmd != BUS_NONE that was not granted.
REQ-018 SHALL keep a 16-entry owner table (valid bit, owner bit) indexed by tag; entry 0 never valid.
REQ-019 SHALL, at clock edge, allocate entry[mem_resp_code] with the granted owner when a BUS_LOAD was granted and mem_resp_code != 0.
REQ-020 SHALL NOT allocate for BUS_STORE grants or when mem_resp_code == 0; the rejected requester retries and owns no state.
REQ-021 SHALL, combinationally, route nonzero mem_resp_tag hitting a valid entry to ic_resp_tag or dc_resp_tag by owner; the other requester's tag output SHALL be 0.
REQ-022 SHALL, when mem_resp_tag is nonzero but its entry is invalid, drive both tag outputs 0 and keep the table unchanged.
REQ-023 SHALL drive resp_data = mem_resp_data unconditionally.
REQ-024 SHALL clear the routed entry at the clock edge; same-cycle retire and allocate of the same tag SHALL leave the entry valid with the new owner.
REQ-025 SHALL update outstanding_cnt by +1 per allocate and -1 per retire; both together SHALL leave it unchanged; it is bounded 0..15.
REQ-026 SHALL, on allocate into an already-valid entry (protocol error), overwrite the owner and leave the count unchanged.

Reset
REQ-027 SHALL, on rst, clear all table valid bits, outstanding_cnt = 0, RR pointer = dc-first.
REQ-028 SHALL drive all outputs to 0/BUS_NONE during a cycle with rst high, regardless of inputs.
REQ-029 SHALL discard responses arriving for tags issued before a mid-operation reset (table empty, so REQ-022 applies).

Configuration
REQ-030 SHALL, with MEM_ARB_RR_EN defined, resolve conflicts round-robin: one-bit pointer toggles to the other requester after each conflict grant; non-conflict grants SHALL NOT move it.
REQ-031 SHALL, without MEM_ARB_RR_EN, use fixed dc priority and contain no pointer state.

Verification
REQ-032 SHALL cover: ic BUS_LOAD addr 0x100 alone, mem_resp_code 3 -> mem_req_addr 0x100, ic_resp_code 3, outstanding_cnt 1 next cycle; later mem_resp_tag 3 -> ic_resp_tag 3, dc_resp_tag 0, cnt 0.
REQ-033 SHALL cover: ic and dc BUS_LOAD same cycle, no RR -> dc granted, ic_hold 1, dc_hold 0, ic_resp_code 0.
REQ-034 SHALL cover: MEM_ARB_RR_EN, three consecutive conflict cycles -> grants dc, ic, dc.
REQ-035 SHALL cover: dc BUS_STORE granted, resp_code 5 -> no table allocate, cnt unchanged; stray mem_resp_tag 5 -> both tag outputs 0.
REQ-036 SHALL cover: tag 7 outstanding for dc, then mem_resp_tag 7 in the same cycle as an ic allocate of tag 7 -> dc_resp_tag 7 that cycle, entry 7 owned by ic afterwards, cnt unchanged.
REQ-037 SHALL cover: rst asserted with 4 tags outstanding -> cnt 0, later mem_resp_tag of any of them routed nowhere.
